// File: rtl/imem_fetch_controller.sv
// Instruction fetch controller: owns the PC, issues one fetch at a time to the
// instruction memory and buffers fetched words in a small queue for decode.
module imem_fetch_controller #(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       MEM_BYTES = 256,
  parameter int unsigned       QDEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_instr,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_pc
);
  // Handshakes: a head word moves to decode on the edge where out_valid and
  // out_ready are both high, and out_valid never depends on out_ready.
  // imem_req/imem_addr stay stable until imem_ack, which may come the same cycle.

  localparam int unsigned       PTR_W     = $clog2(QDEPTH);
  localparam int unsigned       CNT_W     = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(MEM_BYTES - 1);
  localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FAULT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;

  logic [ADDR_W-1:0] q_pc    [QDEPTH];
  logic [31:0]       q_instr [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, cnt_after;

  logic              push, pop, do_eval;
  logic [ADDR_W-1:0] eval_pc;
  logic              eval_legal, can_issue, take_fault;

  function automatic logic is_legal(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && ((a + ADDR_W'(3)) <= LAST_BYTE);
  endfunction

  // Redirect outranks both queue operations in the cycle it is asserted.
  assign push      = (state_q == FETCH) && imem_ack && !redirect_valid;
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign cnt_after = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};

  // Issue is evaluated on the PC that will be current after this edge. A bad PC
  // only faults once every earlier good word has left the queue.
  assign eval_pc    = (state_q == FETCH) ? pc_q + ADDR_W'(4) : pc_q;
  assign eval_legal = is_legal(eval_pc);
  assign can_issue  = !halt && eval_legal && (cnt_after < DEPTH);
  assign take_fault = !halt && !eval_legal && (cnt_after == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= '0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    fault_pc_d = fault_pc_q;
    do_eval    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) pc_d = redirect_pc;
        else                do_eval = 1'b1;
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          pc_d    = eval_pc;
          do_eval = 1'b1;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_ack) state_d = IDLE;
        end else if (imem_ack) begin
          do_eval = 1'b1;
        end
      end
      FAULT: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          state_d    = IDLE;
          fault_pc_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_eval) begin
      state_d = can_issue ? FETCH : (take_fault ? FAULT : IDLE);
      if (can_issue)  addr_d     = eval_pc;
      if (take_fault) fault_pc_d = eval_pc;
    end
  end

  always_comb begin
    imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    imem_addr = imem_req ? addr_q : '0;
    out_valid = (count_q != '0) && (state_q != FAULT);
    out_pc    = out_valid ? q_pc[rd_ptr_q] : '0;
    out_instr = out_valid ? q_instr[rd_ptr_q] : 32'h0;
    fault     = (state_q == FAULT);
    fault_pc  = fault_pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= cnt_after;
    end
  end

  // The requested address, not pc_q, tags the entry: they only differ in DRAIN.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr_q]    <= addr_q;
      q_instr[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Directed bench for imem_fetch_controller: a variable-latency memory model
// answers requests while one initial block walks the scenarios step by step.
module tb_imem_fetch_controller;
  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;
  logic [63:0] fault_pc;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 0;
  int wait_cnt;
  int k;

  logic [31:0] mem_w [0:63];
  logic [63:0] exp_q [$];
  logic [63:0] got_q [$];
  logic [63:0] e_v, g_v;

  imem_fetch_controller #(
    .ADDR_W(64), .RESET_PC(64'h0), .MEM_BYTES(256), .QDEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .fault(fault), .fault_pc(fault_pc)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks after 'lat' waiting cycles (0 = same cycle as req).
  always_comb begin
    imem_ack   = imem_req && (wait_cnt >= lat);
    imem_rdata = imem_ack ? mem_w[imem_addr[7:2]] : 32'h0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                            wait_cnt <= 0;
  end

  // Checkers
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Driver: reset lasts two cycles and is released on a falling edge.
  task automatic do_reset(input logic rdy);
    rst_n          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    out_ready      = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_bit({tag, "_req"},   imem_req,  1'b0);
    chk    ({tag, "_addr"},  imem_addr, 64'h0);
    chk_bit({tag, "_valid"}, out_valid, 1'b0);
    chk    ({tag, "_pc"},    out_pc,    64'h0);
    chk32  ({tag, "_instr"}, out_instr, 32'h0);
    chk_bit({tag, "_fault"}, fault,     1'b0);
    chk    ({tag, "_fpc"},   fault_pc,  64'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_w[i] = 32'hC0DE_0000 | 32'(i << 2);
    mem_w[0] = 32'h0000_2083;
    mem_w[1] = 32'h0080_3103;
    mem_w[2] = 32'h0011_01B3;
    halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    out_ready = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");

    // Zero latency streaming: first word one cycle after the first request.
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    chk_bit("s1_req", imem_req, 1'b1);
    chk("s1_addr0", imem_addr, 64'h0);
    chk_bit("s1_not_yet_valid", out_valid, 1'b0);
    @(negedge clk);
    chk_bit("s1_valid", out_valid, 1'b1);
    chk("s1_pc0", out_pc, 64'h0);
    chk32("s1_instr0", out_instr, 32'h0000_2083);
    chk("s1_addr4", imem_addr, 64'h4);
    @(negedge clk);
    chk("s1_pc4", out_pc, 64'h4);
    chk32("s1_instr4", out_instr, 32'h0080_3103);
    @(negedge clk);
    chk("s1_pc8", out_pc, 64'h8);
    chk32("s1_instr8", out_instr, 32'h0011_01B3);
    halt = 1'b1;
    @(negedge clk);
    chk_bit("s1_halt_no_req", imem_req, 1'b0);
    chk("s1_pc12", out_pc, 64'hC);
    chk32("s1_instr12", out_instr, 32'hC0DE_000C);
    @(negedge clk);
    chk_bit("s1_drained", out_valid, 1'b0);
    chk_bit("s1_halt_idle", imem_req, 1'b0);

    // Backpressure: queue fills to two entries and fetching stops.
    do_reset(1'b0);
    repeat (6) @(negedge clk);
    chk_bit("s2_full_valid", out_valid, 1'b1);
    chk("s2_head0", out_pc, 64'h0);
    chk32("s2_head0_instr", out_instr, 32'h0000_2083);
    chk_bit("s2_full_no_req", imem_req, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("s2_pc4", out_pc, 64'h4);
    chk_bit("s2_refetch_req", imem_req, 1'b1);
    chk("s2_refetch_addr", imem_addr, 64'h8);
    @(negedge clk);
    chk("s2_pc8", out_pc, 64'h8);
    chk32("s2_instr8", out_instr, 32'h0011_01B3);
    halt = 1'b1;
    @(negedge clk);
    chk("s2_pc12", out_pc, 64'hC);
    @(negedge clk);
    chk_bit("s2_empty", out_valid, 1'b0);

    // Latency 3, redirect to 0x20 in the first cycle of the fetch at 0x8.
    lat = 3;
    do_reset(1'b1);
    k = 0;
    while (!(imem_req === 1'b1 && imem_addr === 64'h8) && k < 60) begin
      @(negedge clk); k++;
    end
    chk_bit("s3_reach_fetch8", k < 60, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk_bit("s3_drain_req", imem_req, 1'b1);
    chk("s3_drain_addr_a", imem_addr, 64'h8);
    chk_bit("s3_flushed", out_valid, 1'b0);
    @(negedge clk);
    chk("s3_drain_addr_b", imem_addr, 64'h8);
    k = 0;
    while (imem_req === 1'b1 && imem_addr === 64'h8 && k < 20) begin
      @(negedge clk); k++;
    end
    while (imem_req !== 1'b1 && k < 20) begin
      @(negedge clk); k++;
    end
    chk("s3_next_addr", imem_addr, 64'h20);
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      @(negedge clk); k++;
    end
    chk("s3_next_out_pc", out_pc, 64'h20);
    chk32("s3_next_instr", out_instr, 32'hC0DE_0020);

    // Redirect coinciding with ack and pop: both words are dropped.
    lat = 0;
    do_reset(1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("s4_head_before", out_pc, 64'h0);
    chk_bit("s4_req_before", imem_req, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk_bit("s4_queue_empty", out_valid, 1'b0);
    chk_bit("s4_idle", imem_req, 1'b0);
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      @(negedge clk); k++;
    end
    chk("s4_next_pc", out_pc, 64'h40);
    chk32("s4_next_instr", out_instr, 32'hC0DE_0040);

    // Misaligned redirect faults; a good redirect clears it.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h22;
    @(negedge clk);
    redirect_valid = 1'b0;
    k = 0;
    while (fault !== 1'b1 && k < 20) begin
      @(negedge clk); k++;
    end
    chk_bit("s5_fault", fault, 1'b1);
    chk("s5_fault_pc", fault_pc, 64'h22);
    chk_bit("s5_no_req", imem_req, 1'b0);
    chk_bit("s5_no_valid", out_valid, 1'b0);
    repeat (3) @(negedge clk);
    chk_bit("s5_sticky", fault, 1'b1);
    chk_bit("s5_sticky_no_req", imem_req, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk_bit("s5_cleared", fault, 1'b0);
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      @(negedge clk); k++;
    end
    chk("s5_resume_pc", out_pc, 64'h0);
    chk32("s5_resume_instr", out_instr, 32'h0000_2083);

    // Run up to the end of memory: 0xFC is delivered, 0x100 faults.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hF0;
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_q = {64'hF0, 64'hF4, 64'hF8, 64'hFC};
    got_q.delete();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (fault === 1'b1) break;
      if (out_valid === 1'b1) got_q.push_back(out_pc);
    end
    chk("s6_word_count", 64'(got_q.size()), 64'd4);
    while (exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      g_v = (got_q.size() > 0) ? got_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
      chk("s6_order", g_v, e_v);
    end
    chk_bit("s6_fault", fault, 1'b1);
    chk("s6_fault_pc", fault_pc, 64'h100);
    chk_bit("s6_no_req", imem_req, 1'b0);

    // Asynchronous reset in the middle of an outstanding request.
    lat = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h10;
    @(negedge clk);
    redirect_valid = 1'b0;
    k = 0;
    while (imem_req !== 1'b1 && k < 20) begin
      @(negedge clk); k++;
    end
    chk("s7_req_addr", imem_addr, 64'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s7_async");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
